// File: rtl/se_prog_loader.sv
// Program loader: assembles a little-endian byte stream (length header + words) into 32-bit
// instruction-memory writes. Optional trailing checksum stage enabled by SE_LOADER_CHECKSUM_EN.
module se_prog_loader #(
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byteValid_i,
  output logic              byteReady_o,
  output logic [31:0]       loadData_o,
  output logic [ADDR_W-1:0] loadAddr_o,
  output logic              wrEn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [10:0]       wordCount_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RECV,
    S_WRITE,
`ifdef SE_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       wc_q, wc_d;
  logic              rdy_q, rdy_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef SE_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif
  logic              xfer;

  // Little-endian insertion: byte lane idx of the word being assembled.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign xfer = byteValid_i && rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    word_d  = word_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    rdy_d   = rdy_q;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef SE_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          idx_d   = 2'd0;
          wc_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = 1'b1;
`ifdef SE_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          n_d   = put_byte(n_q, idx_q, byte_i);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (n_d == 32'd0 || n_d > 32'(DEPTH)) begin
              state_d = S_ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
              rdy_d   = 1'b0;
            end else begin
              state_d = S_RECV;
            end
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          word_d = put_byte(word_q, idx_q, byte_i);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Outputs are registered here so they are valid throughout the WRITE cycle.
            state_d = S_WRITE;
            rdy_d   = 1'b0;
            wr_d    = 1'b1;
            data_d  = word_d;
            addr_d  = BASE_ADDR + (ADDR_W'(wc_q) << 2);
`ifdef SE_LOADER_CHECKSUM_EN
            csum_d  = csum_q + word_d;
`endif
          end
        end
      end
      S_WRITE: begin
        wc_d = wc_q + 11'd1;
        if ({21'd0, wc_q} + 32'd1 < n_q) begin
          state_d = S_RECV;
          rdy_d   = 1'b1;
        end else begin
`ifdef SE_LOADER_CHECKSUM_EN
          state_d = S_CHK;
          rdy_d   = 1'b1;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SE_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          word_d = put_byte(word_q, idx_q, byte_i);
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            busy_d = 1'b0;
            rdy_d  = 1'b0;
            if (word_d == csum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      word_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wc_q    <= '0;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SE_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      word_q  <= word_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SE_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byteReady_o = rdy_q;
  assign loadData_o  = data_q;
  assign loadAddr_o  = addr_q;
  assign wrEn_o      = wr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wordCount_o = wc_q;

endmodule

// File: tb/tb_se_prog_loader.sv
// Directed bench for se_prog_loader; checksum scenarios run when SE_LOADER_CHECKSUM_EN is defined.
module tb_se_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byteValid_i = 1'b0;
  logic        byteReady_o;
  logic [31:0] loadData_o;
  logic [63:0] loadAddr_o;
  logic        wrEn_o, busy_o, done_o, err_o;
  logic [10:0] wordCount_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wq_d[$];
  logic [63:0] wq_a[$];

  se_prog_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .byte_i(byte_i),
    .byteValid_i(byteValid_i), .byteReady_o(byteReady_o), .loadData_o(loadData_o),
    .loadAddr_o(loadAddr_o), .wrEn_o(wrEn_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .wordCount_o(wordCount_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrEn_o) begin
      wq_d.push_back(loadData_o);
      wq_a.push_back(loadAddr_o);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_i = b;
    byteValid_i = 1'b1;
    t = 0;
    while (!byteReady_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_assert++; n_fail++;
      $display("FAIL byte_accept_timeout: byteReady_o=%0b required 1", byteReady_o);
    end
    @(negedge clk);
    byteValid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_chk(input logic [31:0] s);
`ifdef SE_LOADER_CHECKSUM_EN
    send_word(s);
`else
    s = s;
`endif
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_assert++; n_fail++;
      $display("FAIL session_end_timeout: busy_o=%0b required 0", busy_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({wrEn_o, byteReady_o, busy_o, done_o, err_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
                         {wrEn_o, byteReady_o, busy_o, done_o, err_o});
    end
    n_assert++;
    if (loadData_o !== 32'h0 || loadAddr_o !== 64'h0 || wordCount_o !== 11'd0) begin
      n_fail++; $display("FAIL reset_data: data=%h addr=%h wc=%0d required 0",
                         loadData_o, loadAddr_o, wordCount_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wq_d.delete(); wq_a.delete();
    pulse_start();
    n_assert++;
    if (busy_o !== 1'b1 || byteReady_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: busy=%b ready=%b required 1 1", busy_o, byteReady_o);
    end
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_chk(32'h0010_00A6);
    wait_idle();
    n_assert++;
    if (wq_d.size() !== 2) begin
      n_fail++; $display("FAIL basic_nwrites: got %0d required 2", wq_d.size());
    end else begin
      n_assert++;
      if (wq_d[0] !== 32'h13 || wq_a[0] !== 64'h0) begin
        n_fail++; $display("FAIL basic_w0: got %h@%h required 00000013@0", wq_d[0], wq_a[0]);
      end
      n_assert++;
      if (wq_d[1] !== 32'h0010_0093 || wq_a[1] !== 64'h4) begin
        n_fail++; $display("FAIL basic_w1: got %h@%h required 00100093@4", wq_d[1], wq_a[1]);
      end
    end
    n_assert++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || wordCount_o !== 11'd2 || byteReady_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: done=%b err=%b wc=%0d rdy=%b required 1 0 2 0",
                         done_o, err_o, wordCount_o, byteReady_o);
    end
    n_assert++;
    if (loadData_o !== 32'h0010_0093 || wrEn_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: data=%h wr=%b required 00100093 0", loadData_o, wrEn_o);
    end
  endtask

  task automatic test_bad_header();
    logic [31:0] hdrs [2];
    hdrs[0] = 32'd0;
    hdrs[1] = 32'd1025;
    for (int h = 0; h < 2; h++) begin
      wq_d.delete(); wq_a.delete();
      pulse_start();
      n_assert++;
      if (done_o !== 1'b0 || err_o !== 1'b0) begin
        n_fail++; $display("FAIL hdr%0d_clear: done=%b err=%b required 0 0", h, done_o, err_o);
      end
      send_word(hdrs[h]);
      repeat (3) @(negedge clk);
      n_assert++;
      if (err_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0 || byteReady_o !== 1'b0) begin
        n_fail++; $display("FAIL hdr%0d_err: err=%b done=%b busy=%b rdy=%b required 1 0 0 0",
                           h, err_o, done_o, busy_o, byteReady_o);
      end
      n_assert++;
      if (wq_d.size() !== 0) begin
        n_fail++; $display("FAIL hdr%0d_nowrite: got %0d writes required 0", h, wq_d.size());
      end
    end
  endtask

  task automatic test_full_depth();
    int bad;
    wq_d.delete(); wq_a.delete();
    pulse_start();
    send_word(32'd1024);
    for (int k = 0; k < 1024; k++) send_word(32'(k));
    send_chk(32'h0007_FE00);
    wait_idle();
    n_assert++;
    if (wq_d.size() !== 1024) begin
      n_fail++; $display("FAIL full_nwrites: got %0d required 1024", wq_d.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 1024; k++)
        if (wq_d[k] !== 32'(k) || wq_a[k] !== 64'(4 * k)) bad++;
      n_assert++;
      if (bad != 0) begin
        n_fail++; $display("FAIL full_contents: %0d bad writes required 0", bad);
      end
      n_assert++;
      if (wq_d[1023] !== 32'h3FF || wq_a[1023] !== 64'hFFC) begin
        n_fail++; $display("FAIL full_last: got %h@%h required 000003ff@ffc",
                           wq_d[1023], wq_a[1023]);
      end
    end
    n_assert++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || wordCount_o !== 11'd1024) begin
      n_fail++; $display("FAIL full_status: done=%b err=%b wc=%0d required 1 0 1024",
                         done_o, err_o, wordCount_o);
    end
  endtask

  task automatic test_gap_and_restart();
    int rdy_bad;
    wq_d.delete(); wq_a.delete();
    pulse_start();
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    rdy_bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (byteReady_o !== 1'b1) rdy_bad++;
      if (c == 5) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    n_assert++;
    if (rdy_bad != 0 || wq_d.size() !== 0) begin
      n_fail++; $display("FAIL gap_stall: rdy_low=%0d writes=%0d required 0 0", rdy_bad, wq_d.size());
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0093);
    send_chk(32'h0010_00A6);
    wait_idle();
    n_assert++;
    if (wq_d.size() !== 2 || wq_d[0] !== 32'h13 || wq_d[1] !== 32'h0010_0093) begin
      n_fail++; $display("FAIL gap_words: n=%0d w0=%h required 2 00000013",
                         wq_d.size(), (wq_d.size() > 0) ? wq_d[0] : 32'hx);
    end
    n_assert++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || wordCount_o !== 11'd2) begin
      n_fail++; $display("FAIL gap_status: done=%b err=%b wc=%0d required 1 0 2",
                         done_o, err_o, wordCount_o);
    end
  endtask

  task automatic test_reset_midsession();
    int nw;
    wq_d.delete(); wq_a.delete();
    pulse_start();
    send_word(32'd5);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_byte(8'h33);
    send_byte(8'h33);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({wrEn_o, byteReady_o, busy_o, done_o, err_o} !== 5'b0 || wordCount_o !== 11'd0 ||
        loadData_o !== 32'h0 || loadAddr_o !== 64'h0) begin
      n_fail++; $display("FAIL midreset_outputs: ctrl=%b wc=%0d data=%h required 00000 0 0",
                         {wrEn_o, byteReady_o, busy_o, done_o, err_o}, wordCount_o, loadData_o);
    end
    nw = wq_d.size();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++;
    if (wq_d.size() !== nw || nw !== 2) begin
      n_fail++; $display("FAIL midreset_nowrite: writes=%0d required 2", wq_d.size());
    end
    wq_d.delete(); wq_a.delete();
    pulse_start();
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    send_chk(32'hDEAD_BEEF);
    wait_idle();
    n_assert++;
    if (wq_d.size() !== 1 || wq_d[0] !== 32'hDEAD_BEEF || wq_a[0] !== 64'h0 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL midreset_reload: n=%0d done=%b required 1 write deadbeef@0 done 1",
                         wq_d.size(), done_o);
    end
  endtask

`ifdef SE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] sums [2];
    sums[0] = 32'h0010_00A6;
    sums[1] = 32'h0010_00A7;
    for (int s = 0; s < 2; s++) begin
      wq_d.delete(); wq_a.delete();
      pulse_start();
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h0010_0093);
      send_word(sums[s]);
      wait_idle();
      n_assert++;
      if (done_o !== (s == 0) || err_o !== (s == 1)) begin
        n_fail++; $display("FAIL chk%0d_status: done=%b err=%b required %0d %0d",
                           s, done_o, err_o, s == 0, s == 1);
      end
      n_assert++;
      if (wq_d.size() !== 2) begin
        n_fail++; $display("FAIL chk%0d_writes: got %0d required 2", s, wq_d.size());
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_header();
    test_full_depth();
    test_gap_and_restart();
    test_reset_midsession();
`ifdef SE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
